// File: rtl/pipelined_line_memory_if.sv
// Request/response bus of the line memory. The memory is the slave; the
// cache arbiter (or a bench) is the master.
interface pipelined_line_memory_if #(
    parameter int LINE_WIDTH = 128,
    parameter int PA_WIDTH   = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_write;
    logic [PA_WIDTH-1:0]   i_req_addr;
    logic [LINE_WIDTH-1:0] i_req_data;
    logic [ID_WIDTH-1:0]   i_req_id;
    logic                  o_resp_valid;
    logic                  i_resp_ready;
    logic [LINE_WIDTH-1:0] o_resp_data;
    logic [ID_WIDTH-1:0]   o_resp_id;
    logic                  o_resp_write;
    logic                  o_busy;

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_data, i_req_id, i_resp_ready,
        input  o_req_ready, o_resp_valid, o_resp_data, o_resp_id, o_resp_write, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_req_id, i_resp_ready,
        output o_req_ready, o_resp_valid, o_resp_data, o_resp_id, o_resp_write, o_busy
    );
endinterface

// File: rtl/pipelined_line_memory.sv
// Line-granular backing memory: fixed-latency never-stalling request pipeline
// feeding a response FIFO. Admission is credit based (FIFO entries plus
// in-flight responders), so a response can never be dropped.
// Optional feature macro: MEM_WRITE_ACK_EN (writes return an acknowledgement
// and consume a credit; o_resp_write flags them).
module pipelined_line_memory #(
    parameter int LINE_WIDTH = 128,
    parameter int PA_WIDTH   = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int ID_WIDTH   = 4,
    parameter int LATENCY    = 4,
    parameter int RESP_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    pipelined_line_memory_if.slave bus
);
    localparam int OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] idx;
        logic [LINE_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } op_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } resp_t;

    logic [LINE_WIDTH-1:0] mem [2**ADDR_WIDTH];
    op_t                   stage [LATENCY];
    logic [LATENCY-1:0]    vld_pipe;
    resp_t                 fifo [RESP_DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_W-1:0]      fifo_count, inflight;

    logic  req_ready, accept, takes_credit, push, pop, resp_valid;
    op_t   req_op, last;
    resp_t head_e, push_e;
    logic  unused_addr;

    // Only the line-index bits of the byte address matter.
    assign unused_addr = ^bus.i_req_addr;

`ifdef MEM_WRITE_ACK_EN
    logic fifo_wr [RESP_DEPTH];
    assign takes_credit = 1'b1;
`else
    assign takes_credit = !bus.i_req_write;
`endif

    // Credits come from registered counters only, never from i_resp_ready.
    assign req_ready = (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W+1)'(RESP_DEPTH)) && !rst;
    assign accept    = bus.i_req_valid && req_ready;

    assign req_op.write = bus.i_req_write;
    assign req_op.idx   = bus.i_req_addr[OFFSET +: ADDR_WIDTH];
    assign req_op.data  = bus.i_req_data;
    assign req_op.id    = bus.i_req_id;

    assign last = stage[LATENCY-1];
`ifdef MEM_WRITE_ACK_EN
    assign push = vld_pipe[LATENCY-1];
`else
    assign push = vld_pipe[LATENCY-1] && !last.write;
`endif
    assign push_e.data = last.write ? '0 : mem[last.idx];
    assign push_e.id   = last.id;

    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid && bus.i_resp_ready;
    assign head_e     = fifo[head];

    assign bus.o_req_ready  = req_ready;
    assign bus.o_resp_valid = resp_valid;
    assign bus.o_resp_data  = resp_valid ? head_e.data : '0;
    assign bus.o_resp_id    = resp_valid ? head_e.id : '0;
    assign bus.o_busy       = (|vld_pipe) || resp_valid;
`ifdef MEM_WRITE_ACK_EN
    assign bus.o_resp_write = resp_valid && fifo_wr[head];
`else
    assign bus.o_resp_write = 1'b0;
`endif

    // Valid shift register: bubbles travel as zeros, reset kills everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Payload shift register; contents are don't-care wherever valid is low.
    always_ff @(posedge clk) begin
        stage[0] <= req_op;
        for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end

    // Execute writes at the last stage; a later read sees the data one edge on.
    always_ff @(posedge clk) begin
        if (vld_pipe[LATENCY-1] && last.write) mem[last.idx] <= last.data;
    end

    // Response FIFO storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[tail] <= push_e;
`ifdef MEM_WRITE_ACK_EN
            fifo_wr[tail] <= last.write;
`endif
        end
    end

    // Pointers, occupancy and credit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            if (push) tail <= (tail == PTR_W'(RESP_DEPTH-1)) ? '0 : tail + 1'b1;
            if (pop)  head <= (head == PTR_W'(RESP_DEPTH-1)) ? '0 : head + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            case ({accept && takes_credit, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipelined_line_memory.sv
// Scoreboard bench for pipelined_line_memory: requests push expected
// responses into a queue, a negedge monitor pops and compares them.
module tb_pipelined_line_memory;
    localparam int LW = 128, PAW = 32, AW = 6, IDW = 4, LAT = 4, DEPTH = 4;
    localparam int OFFSET = 4;

    typedef struct {
        logic [IDW-1:0] id;
        logic [LW-1:0]  data;
        logic           wr;
    } exp_t;

    logic clk, rst;
    int   checks, failures;
    exp_t sb [$];
    logic [LW-1:0] model [2**AW];

    pipelined_line_memory_if #(.LINE_WIDTH(LW), .PA_WIDTH(PAW), .ID_WIDTH(IDW)) bus ();

    pipelined_line_memory #(
        .LINE_WIDTH(LW), .PA_WIDTH(PAW), .ADDR_WIDTH(AW),
        .ID_WIDTH(IDW), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every response taken by the consumer must match the queue head.
    always @(negedge clk) begin
        if (!rst && bus.o_resp_valid && bus.i_resp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected id=%0d data=%h wr=%0b", bus.o_resp_id, bus.o_resp_data, bus.o_resp_write);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.o_resp_id !== e.id || bus.o_resp_data !== e.data || bus.o_resp_write !== e.wr) begin
                    failures++;
                    $display("FAIL resp_order got id=%0d data=%h wr=%0b want id=%0d data=%h wr=%0b",
                             bus.o_resp_id, bus.o_resp_data, bus.o_resp_write, e.id, e.data, e.wr);
                end
            end
        end
    end

    // Overflow watch: a push into a full FIFO would lose a response.
    always @(negedge clk) begin
        if (!rst && dut.push && dut.fifo_count == DEPTH[2:0]) begin
            checks++;
            failures++;
            $display("FAIL fifo_overflow count=%0d", dut.fifo_count);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits for a credit, issues one request, records the expected response.
    task automatic issue(input logic wr, input logic [PAW-1:0] addr, input logic [LW-1:0] data, input logic [IDW-1:0] id);
        int n = 0;
        logic [AW-1:0] idx;
        exp_t e;
        idx = addr[OFFSET +: AW];
        while (!bus.o_req_ready && n < 100) begin
            cycle();
            n++;
        end
        if (!bus.o_req_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout id=%0d ready=%0b want 1", id, bus.o_req_ready);
            return;
        end
        bus.i_req_valid = 1'b1;
        bus.i_req_write = wr;
        bus.i_req_addr  = addr;
        bus.i_req_data  = data;
        bus.i_req_id    = id;
        cycle();
        bus.i_req_valid = 1'b0;
        e.id = id;
        if (wr) begin
            model[idx] = data;
`ifdef MEM_WRITE_ACK_EN
            e.data = '0;
            e.wr   = 1'b1;
            sb.push_back(e);
`endif
        end else begin
            e.data = model[idx];
            e.wr   = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.i_resp_ready = 1'b1;
        while ((sb.size() != 0 || bus.o_busy) && n < 300) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0 || bus.o_busy) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d busy=%0b want 0", sb.size(), bus.o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_req_ready, bus.o_resp_valid, bus.o_busy, bus.o_resp_write} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags ready=%0b valid=%0b busy=%0b wr=%0b want 0",
                     bus.o_req_ready, bus.o_resp_valid, bus.o_busy, bus.o_resp_write);
        end
        checks++;
        if (bus.o_resp_id !== '0 || bus.o_resp_data !== '0) begin
            failures++;
            $display("FAIL reset_data id=%0d data=%h want 0", bus.o_resp_id, bus.o_resp_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%0b want 1", bus.o_req_ready);
        end
        #1;
    endtask

    task automatic test_fill();
        bus.i_resp_ready = 1'b1;
        for (int i = 0; i < 2**AW; i++)
            issue(1'b1, PAW'(i << OFFSET), {$urandom, $urandom, $urandom, $urandom}, IDW'(i));
        drain();
    endtask

    task automatic test_raw();
        int k;
        bus.i_resp_ready = 1'b1;
        issue(1'b1, 32'h50, {16{8'hA5}}, 4'd1);
        issue(1'b0, 32'h50, '0, 4'd2);
        checks++;
        if (sb[sb.size()-1].data !== {16{8'hA5}}) begin
            failures++;
            $display("FAIL raw_model data=%h want %h", sb[sb.size()-1].data, {16{8'hA5}});
        end
        for (k = 1; k <= 12; k++) begin
            cycle();
            if (bus.o_resp_valid && bus.o_resp_id == 4'd2) break;
        end
        checks++;
        if (k != LAT) begin
            failures++;
            $display("FAIL raw_latency got=%0d want %0d", k, LAT);
        end
        drain();
    endtask

    task automatic test_alias();
        bus.i_resp_ready = 1'b1;
        issue(1'b1, 32'h5F, {4{32'hC0DE_1234}}, 4'd3);
        issue(1'b0, 32'h450, '0, 4'd4);
        issue(1'b0, 32'h50, '0, 4'd5);
        issue(1'b0, 32'h5A, '0, 4'd6);
        drain();
    endtask

    task automatic test_back_to_back();
        bus.i_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, PAW'(i << OFFSET), '0, IDW'(i));
        checks++;
        if (bus.o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_drop got=%0b want 0", bus.o_req_ready);
        end
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = 32'h90;
        bus.i_req_id    = 4'd9;
        cycle();
        bus.i_req_valid = 1'b0;
        repeat (6) cycle();
        checks++;
        if (dut.fifo_count !== 3'd4 || bus.o_req_ready !== 1'b0 || bus.o_resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full count=%0d ready=%0b valid=%0b want 4 0 1",
                     dut.fifo_count, bus.o_req_ready, bus.o_resp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.o_resp_id !== 4'd0 || bus.o_resp_data !== model[0]) begin
                failures++;
                $display("FAIL b2b_stable id=%0d data=%h want 0 %h", bus.o_resp_id, bus.o_resp_data, model[0]);
            end
        end
        bus.i_resp_ready = 1'b1;
        checks++;
        if (bus.o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_before_pop got=%0b want 0", bus.o_req_ready);
        end
        cycle();
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_after_pop got=%0b want 1", bus.o_req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.o_resp_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_stream step=%0d valid=%0b want 1", i, bus.o_resp_valid);
            end
            cycle();
        end
        checks++;
        if (bus.o_resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty valid=%0b want 0", bus.o_resp_valid);
        end
        drain();
    endtask

    task automatic test_push_pop_wrap();
        bus.i_resp_ready = 1'b0;
        issue(1'b0, 32'h140, '0, 4'd10);
        issue(1'b0, 32'h150, '0, 4'd11);
        repeat (5) cycle();
        checks++;
        if (dut.fifo_count !== 3'd2) begin
            failures++;
            $display("FAIL wrap_prefill count=%0d want 2", dut.fifo_count);
        end
        for (int p = 0; p < 8; p++) begin
            issue(1'b0, PAW'((30 + p) << OFFSET), '0, IDW'(p));
            repeat (LAT - 1) cycle();
            bus.i_resp_ready = 1'b1;
            cycle();
            bus.i_resp_ready = 1'b0;
            checks++;
            if (dut.fifo_count !== 3'd2) begin
                failures++;
                $display("FAIL wrap_count pair=%0d count=%0d want 2", p, dut.fifo_count);
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int bad = 0;
        logic [LW-1:0] old9;
        old9 = model[9];
        bus.i_resp_ready = 1'b0;
        issue(1'b0, 32'h280, '0, 4'd12);
        repeat (5) cycle();
        issue(1'b0, 32'h290, '0, 4'd13);
`ifndef MEM_WRITE_ACK_EN
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_addr  = 32'h90;
        bus.i_req_data  = ~old9;
        bus.i_req_id    = 4'd5;
        cycle();
        bus.i_req_valid = 1'b0;
`endif
        issue(1'b0, 32'h2A0, '0, 4'd14);
        issue(1'b0, 32'h2B0, '0, 4'd15);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_req_ready, bus.o_busy} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_flags valid=%0b ready=%0b busy=%0b want 0",
                     bus.o_resp_valid, bus.o_req_ready, bus.o_busy);
        end
        cycle();
        cycle();
        checks++;
        if (bus.o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready_held got=%0b want 0", bus.o_req_ready);
        end
        rst = 1'b0;
        bus.i_resp_ready = 1'b1;
        cycle();
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready_after got=%0b want 1", bus.o_req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.o_resp_valid !== 1'b0) bad++;
            cycle();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midrst_stale cycles_valid=%0d want 0", bad);
        end
        issue(1'b0, 32'h90, '0, 4'd6);
        checks++;
        if (sb[0].data !== old9) begin
            failures++;
            $display("FAIL midrst_model data=%h want %h", sb[0].data, old9);
        end
        drain();
    endtask

`ifdef MEM_WRITE_ACK_EN
    task automatic test_write_ack();
        bus.i_resp_ready = 1'b1;
        issue(1'b1, 32'hA0, {4{32'hDEAD_BEEF}}, 4'd7);
        drain();
        bus.i_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b1, PAW'((50 + i) << OFFSET), {4{$urandom}}, IDW'(i));
        checks++;
        if (bus.o_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ack_credit ready=%0b want 0", bus.o_req_ready);
        end
        drain();
        issue(1'b0, 32'hA0, '0, 4'd8);
        drain();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.i_req_valid  = 1'b0;
        bus.i_req_write  = 1'b0;
        bus.i_req_addr   = '0;
        bus.i_req_data   = '0;
        bus.i_req_id     = '0;
        bus.i_resp_ready = 1'b0;
        test_reset();
        test_fill();
        test_raw();
        test_alias();
        test_back_to_back();
        test_push_pop_wrap();
        test_reset_midflight();
`ifdef MEM_WRITE_ACK_EN
        test_write_ack();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_line_memory.md
Name: pipelined_line_memory

Overview:
Parametrised line-granular backing memory model sitting behind the cache arbiter.
- Accepts one read or write request per cycle into a fixed-latency, never-stalling pipeline.
- Returns read data with the request ID through a response FIFO with ready/valid backpressure.
- Uses credit-based admission, so no in-flight response is ever dropped; replaces the single-depth, stall-on-full memory model.

Parameters:
- LINE_WIDTH, 128: bits per line; a multiple of 8, and LINE_WIDTH/8 is a power of two.
- PA_WIDTH, 32: byte-address width of i_req_addr.
- ADDR_WIDTH, 6: line-index width; the memory holds 2**ADDR_WIDTH lines.
- ID_WIDTH, 4: request/response tag width.
- LATENCY, 4: pipeline depth in cycles; must be at least 1.
- RESP_DEPTH, 4: response FIFO entries; must be at least 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- i_req_valid, input, 1: request present.
- o_req_ready, output, 1: request may be accepted this cycle.
- i_req_write, input, 1: 1 = write, 0 = read.
- i_req_addr, input, PA_WIDTH: byte address.
- i_req_data, input, LINE_WIDTH: write line data.
- i_req_id, input, ID_WIDTH: request tag.
- o_resp_valid, output, 1: response available.
- i_resp_ready, input, 1: consumer takes the response.
- o_resp_data, output, LINE_WIDTH: read line data.
- o_resp_id, output, ID_WIDTH: tag of the response.
- o_resp_write, output, 1: response is a write acknowledgement (optional feature only).
- o_busy, output, 1: pipeline or FIFO non-empty.

Behaviour:
- Line index:
  - OFFSET = log2(LINE_WIDTH/8).
  - Index = i_req_addr[OFFSET+ADDR_WIDTH-1 : OFFSET].
  - Bits below OFFSET and above the index are ignored.
  - All indices are valid; there is no out-of-range case.
- Accept: a request is accepted on an edge where i_req_valid && o_req_ready. It is loaded into stage 0 together with addr, data, write and id.
- Pipeline:
  - LATENCY stage registers, each carrying a valid bit.
  - Shifts every cycle unconditionally and never stalls.
  - Bubbles are carried as valid=0.
- Execute: on the edge where an op sits in stage LATENCY-1:
  - Valid write: writes the full line to mem.
  - Valid read: pushes {mem[index], id} into the response FIFO.
- Latency: with an empty FIFO, o_resp_valid rises LATENCY edges after the accepting edge. For example, LATENCY=4: accept at edge 0, response visible after edge 4.
- Ordering:
  - Strictly in order; responses return in accept order.
  - A read accepted after a write to the same line returns the new data, even when accepted on the cycle immediately after the write.
- Credits:
  - inflight = count of valid reads in the pipeline.
  - o_req_ready = (fifo_count + inflight < RESP_DEPTH) && !rst.
  - Depends on registered state only, with no combinational path from i_resp_ready. A pop in the current cycle frees a credit starting the next cycle.
  - Writes need no credit unless the optional feature is enabled.
- Counters on the same edge:
  - inflight changes by +1 on a read accept and -1 on a FIFO push; both together leave it unchanged.
  - fifo_count changes by +1 on a push and -1 on a pop (o_resp_valid && i_resp_ready); both together leave it unchanged.
- FIFO:
  - Head and tail pointers wrap modulo RESP_DEPTH.
  - Outputs are driven from the head entry.
  - o_resp_valid = (fifo_count != 0).
  - o_resp_data and o_resp_id hold stable while valid && !ready.
  - Overflow is impossible by construction. The verification bench asserts push never occurs when fifo_count == RESP_DEPTH.
- o_busy = any pipeline stage valid || fifo_count != 0.
- Reset:
  - Clears all stage valid bits, FIFO pointers, fifo_count and inflight.
  - Outputs: o_resp_valid=0, o_resp_data=0, o_resp_id=0, o_resp_write=0, o_busy=0, o_req_ready=0 while rst is high.
  - Memory contents are not cleared.
  - Reset mid-operation discards all in-flight ops. A write not yet at stage LATENCY-1 does not reach mem.

Optional Feature:
Macro: MEM_WRITE_ACK_EN.
- Defined:
  - Writes also consume a credit: inflight counts reads and writes.
  - On execute, a write pushes {data=0, id, write=1}; reads push write=0.
  - o_resp_write reflects the head entry.
- Undefined:
  - Writes produce no response and consume no credit.
  - o_resp_write is tied to 0.

Test Plan:
- Write line 5 = 0xA5..A5 with id 1, then read line 5 with id 2 on the next cycle → one response: id 2, data 0xA5..A5, 4 cycles after the read accept (LATENCY=4). Without the feature, no response for id 1.
- Back-to-back reads with ids 0..3, i_resp_ready=0 → o_req_ready drops after the 4th accept; FIFO fills to 4; outputs stable at id 0. Raise ready → ids 0,1,2,3 in order, one per cycle; o_req_ready returns 1 the cycle after the first pop.
- Byte addresses 0x50 and 0x5F with LINE_WIDTH=128 → same line index 5; address 0x450 with ADDR_WIDTH=6 aliases to index 5.
- Simultaneous push and pop with fifo_count=2 → count stays 2 and the pointers wrap correctly across 8 further pairs.
- Assert rst with 3 reads in flight and 1 FIFO entry → o_resp_valid=0 and o_req_ready=0 during reset; after release, no stale responses and o_req_ready=1.
- MEM_WRITE_ACK_EN defined: write id 7 → response id 7, o_resp_write=1, data 0; with 4 writes outstanding, o_req_ready=0.
